// File: rtl/nvlink_framing_decode_pkg.sv
// nvlink_pkg: shared widths, flit field offsets, flit struct, FSM states.
// Imported by the framing decoder, its interface and the testbench.
package nvlink_pkg;

  localparam int PAYLOAD_W = 96;
  localparam int COH_W     = 8;
  localparam int SEQ_W     = 24;
  localparam int FLIT_W    = PAYLOAD_W + COH_W + SEQ_W;

  localparam int PAYLOAD_LSB = 0;
  localparam int SEQ_LSB     = PAYLOAD_W;
  localparam int COH_LSB     = PAYLOAD_W + SEQ_W;

  typedef struct packed {
    logic [COH_W-1:0]     coh;
    logic [SEQ_W-1:0]     seq;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

endpackage

// File: rtl/nvlink_framing_decode_if.sv
// Receive flit stream: valid_in qualifies flit_in. No back-pressure.
// master drives the flit, slave (the decoder) consumes it.
interface nvlink_framing_decode_if
  import nvlink_pkg::*;
#(
  parameter int FLIT_W = nvlink_pkg::FLIT_W
);

  logic              valid_in;
  logic [FLIT_W-1:0] flit_in;

  modport master (
    output valid_in,
    output flit_in
  );

  modport slave (
    input valid_in,
    input flit_in
  );

endinterface

// File: rtl/nvlink_framing_decode_sat_counter.sv
// Saturating accumulator: cnt += inc, clamped to all-ones; clr wins.
// Ports: clk, rst_n (sync, active-low), clr, inc[INC_W], cnt[W].
module nvlink_sat_counter #(
  parameter int W     = 16,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     cnt
);

  // One spare bit over the wider operand so the carry is never lost.
  localparam int SW = ((INC_W > W) ? INC_W : W) + 1;

  logic [SW-1:0] sum;
  logic [SW-1:0] cap;

  assign sum = SW'(cnt) + SW'(inc);
  assign cap = SW'({W{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (sum > cap) begin
      cnt <= '1;
    end else begin
      cnt <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/nvlink_framing_decode.sv
// Flit framing decoder: splits flits, tracks expected seq, counts errors.
// Ports: clk, rst_n, rx (flit stream), stats_clr, decoded fields, stats.
module nvlink_framing_decode
  import nvlink_pkg::*;
#(
  parameter int PAYLOAD_W   = nvlink_pkg::PAYLOAD_W,
  parameter int COH_W       = nvlink_pkg::COH_W,
  parameter int SEQ_W       = nvlink_pkg::SEQ_W,
  parameter int CNT_W       = 16,
  parameter bit DROP_ON_ERR = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nvlink_framing_decode_if.slave rx,
  input  logic                 stats_clr,
  output logic                 valid_out,
  output logic [PAYLOAD_W-1:0] payload_out,
  output logic [COH_W-1:0]     coh_bits_out,
  output logic [SEQ_W-1:0]     seq_out,
  output logic                 seq_err,
  output logic                 locked,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     lost_cnt
);

  localparam int SEQ_LO = PAYLOAD_W;
  localparam int COH_LO = PAYLOAD_W + SEQ_W;

  state_t           state;
  logic [SEQ_W-1:0] exp_seq;
  logic [SEQ_W-1:0] rx_seq;
  logic [SEQ_W-1:0] delta;
  logic             mism;
  logic             fwd;
  logic [SEQ_W-1:0] lost_inc;

  assign rx_seq = rx.flit_in[SEQ_LO +: SEQ_W];
  assign delta  = rx_seq - exp_seq;
  assign mism   = rx.valid_in && (state == LOCKED) && (delta != '0);
  // Upper half of the modular distance means a replay, not missing flits.
  assign fwd      = !delta[SEQ_W-1];
  assign lost_inc = (mism && fwd) ? delta : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= HUNT;
      exp_seq      <= '0;
      valid_out    <= 1'b0;
      seq_err      <= 1'b0;
      locked       <= 1'b0;
      payload_out  <= '0;
      coh_bits_out <= '0;
      seq_out      <= '0;
    end else begin
      valid_out <= rx.valid_in && !(DROP_ON_ERR && mism);
      seq_err   <= mism;
      if (rx.valid_in) begin
        unique case (state)
          HUNT:   state <= LOCKED;
          LOCKED: state <= LOCKED;
          default: state <= HUNT;
        endcase
        // Clean or not, the next expected ID follows the received one.
        exp_seq      <= rx_seq + 1'b1;
        locked       <= 1'b1;
        payload_out  <= rx.flit_in[PAYLOAD_W-1:0];
        coh_bits_out <= rx.flit_in[COH_LO +: COH_W];
        seq_out      <= rx_seq;
      end
    end
  end

  nvlink_sat_counter #(
    .W     (CNT_W),
    .INC_W (1)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stats_clr),
    .inc   (mism),
    .cnt   (err_cnt)
  );

  nvlink_sat_counter #(
    .W     (CNT_W),
    .INC_W (SEQ_W)
  ) u_lost_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stats_clr),
    .inc   (lost_inc),
    .cnt   (lost_cnt)
  );

endmodule

// File: tb/tb_nvlink_framing_decode.sv
// Directed bench: two decoders share one flit stream; b uses DROP_ON_ERR=1
// and 4-bit counters for the drop and saturation cases.
module tb_nvlink_framing_decode;
  import nvlink_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stats_clr = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  nvlink_framing_decode_if #(.FLIT_W(FLIT_W)) bus ();

  logic                 a_vo, a_se, a_lk;
  logic [PAYLOAD_W-1:0] a_pl;
  logic [COH_W-1:0]     a_coh;
  logic [SEQ_W-1:0]     a_seq;
  logic [15:0]          a_err, a_lost;

  logic                 b_vo, b_se, b_lk;
  logic [PAYLOAD_W-1:0] b_pl;
  logic [COH_W-1:0]     b_coh;
  logic [SEQ_W-1:0]     b_seq;
  logic [3:0]           b_err, b_lost;

  nvlink_framing_decode u_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (bus),
    .stats_clr    (stats_clr),
    .valid_out    (a_vo),
    .payload_out  (a_pl),
    .coh_bits_out (a_coh),
    .seq_out      (a_seq),
    .seq_err      (a_se),
    .locked       (a_lk),
    .err_cnt      (a_err),
    .lost_cnt     (a_lost)
  );

  nvlink_framing_decode #(
    .CNT_W       (4),
    .DROP_ON_ERR (1'b1)
  ) u_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (bus),
    .stats_clr    (stats_clr),
    .valid_out    (b_vo),
    .payload_out  (b_pl),
    .coh_bits_out (b_coh),
    .seq_out      (b_seq),
    .seq_err      (b_se),
    .locked       (b_lk),
    .err_cnt      (b_err),
    .lost_cnt     (b_lost)
  );

  function automatic flit_t mk(input logic [SEQ_W-1:0] s);
    flit_t f;
    f.coh     = s[7:0] ^ 8'h5a;
    f.seq     = s;
    f.payload = {s, ~s, s ^ 24'h123456, 24'hc0ffee};
    return f;
  endfunction

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.valid_in = 1'b0;
    stats_clr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_vo", a_vo, 0);
    chk("rst_lk", a_lk, 0);
    chk("rst_err", a_err, 0);
    chk("rst_lost", a_lost, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [SEQ_W-1:0] s, input logic clr);
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.flit_in = mk(s);
    stats_clr = clr;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    stats_clr = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.valid_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  flit_t ef;
  logic [SEQ_W-1:0] sq5 [4] = '{24'd5, 24'd6, 24'd10, 24'd11};
  logic [SEQ_W-1:0] sq7 [4] = '{24'd7, 24'd8, 24'd8, 24'd9};
  logic [SEQ_W-1:0] sqw [4] = '{24'hfffffe, 24'hffffff, 24'h0, 24'h1};

  initial begin
    bus.valid_in = 1'b0;
    bus.flit_in = '0;

    do_reset();
    chk("pre_lock", a_lk, 0);
    for (int i = 0; i < 10; i++) begin
      send(SEQ_W'(i), 1'b0);
      ef = mk(SEQ_W'(i));
      chk("inc_vo", a_vo, 1);
      chk("inc_seq", a_seq, ef.seq);
      chk("inc_pl", a_pl, ef.payload);
      chk("inc_coh", a_coh, ef.coh);
      chk("inc_se", a_se, 0);
      chk("inc_lk", a_lk, 1);
    end
    idle();
    chk("idle_vo", a_vo, 0);
    chk("idle_hold", a_seq, 9);
    chk("inc_err", a_err, 0);
    chk("inc_lost", a_lost, 0);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(sqw[i], 1'b0);
      chk("wrap_se", a_se, 0);
      chk("wrap_vo", a_vo, 1);
    end
    chk("wrap_err", a_err, 0);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(sq5[i], 1'b0);
      chk("gap_se", a_se, i == 2);
      chk("gap_vo", a_vo, 1);
      chk("gap_bvo", b_vo, i != 2);
      chk("gap_bse", b_se, i == 2);
    end
    chk("gap_err", a_err, 1);
    chk("gap_lost", a_lost, 3);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(sq7[i], 1'b0);
      chk("dup_se", a_se, i == 2);
    end
    chk("dup_err", a_err, 1);
    chk("dup_lost", a_lost, 0);

    do_reset();
    send(24'd1, 1'b0);
    send(24'd2, 1'b0);
    chk("drop_b2", b_vo, 1);
    send(24'd5, 1'b0);
    chk("drop_bvo", b_vo, 0);
    chk("drop_bse", b_se, 1);
    chk("drop_blost", b_lost, 2);
    chk("drop_avo", a_vo, 1);

    do_reset();
    send(24'd0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      send(SEQ_W'(2 * i), 1'b0);
    end
    chk("sat_berr", b_err, 15);
    chk("sat_blost", b_lost, 15);
    chk("sat_aerr", a_err, 20);
    chk("sat_alost", a_lost, 20);
    send(24'd100, 1'b1);
    chk("clr_se", a_se, 1);
    chk("clr_aerr", a_err, 0);
    chk("clr_alost", a_lost, 0);
    chk("clr_berr", b_err, 0);
    chk("clr_blost", b_lost, 0);
    chk("clr_lk", a_lk, 1);
    send(24'd101, 1'b0);
    chk("clr_next", a_se, 0);
    send(24'h020065, 1'b0);
    chk("big_lost", a_lost, 16'hffff);
    chk("big_err", a_err, 1);
    send(24'd5, 1'b0);
    chk("back_se", a_se, 1);
    chk("back_lost", a_lost, 16'hffff);
    chk("back_err", a_err, 2);

    do_reset();
    send(24'd3, 1'b0);
    send(24'd4, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.valid_in = 1'b1;
    bus.flit_in = mk(24'd5);
    @(posedge clk);
    #1;
    chk("mrst_vo", a_vo, 0);
    chk("mrst_seq", a_seq, 0);
    chk("mrst_lk", a_lk, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.valid_in = 1'b0;
    send(24'd77, 1'b0);
    chk("mrst_hunt_vo", a_vo, 1);
    chk("mrst_hunt_se", a_se, 0);
    chk("mrst_hunt_seq", a_seq, 77);
    send(24'd78, 1'b0);
    chk("mrst_clean", a_se, 0);
    chk("mrst_err", a_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nvlink_framing_decode.md
Name: nvlink_framing_decode

Overview:
- Receive-side counterpart of the NVLink-style flit framer.
- Splits each incoming flit into coherence bits, sequence ID and payload, and tracks the expected sequence ID.
- Flags gaps and duplicates, and keeps saturating error and lost-flit statistics.
- Sits between the link-layer receive path and the upper-layer consumer. It has no back-pressure.

Parameters:
- PAYLOAD_W, 96: data payload width.
- COH_W, 8: coherence/metadata bits width.
- SEQ_W, 24: sequence ID width; also the width of the modular arithmetic.
- CNT_W, 16: width of the statistics counters.
- DROP_ON_ERR, 0: 1 suppresses valid_out for a flit with a sequence error; 0 forwards it flagged.

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- valid_in  in  1  flit_in carries a flit this cycle
- flit_in  in  PAYLOAD_W+COH_W+SEQ_W  layout {coh[COH_W], seq[SEQ_W], payload[PAYLOAD_W]}, MSB first
- stats_clr  in  1  synchronous clear of err_cnt and lost_cnt
- valid_out  out  1  decoded flit valid
- payload_out  out  PAYLOAD_W  flit bits [PAYLOAD_W-1:0]
- coh_bits_out  out  COH_W  flit top COH_W bits
- seq_out  out  SEQ_W  received sequence ID
- seq_err  out  1  qualifies valid_out cycle (or the suppressed cycle); received seq != expected
- locked  out  1  first flit seen since reset; expected-seq tracking active
- err_cnt  out  CNT_W  saturating count of seq_err events
- lost_cnt  out  CNT_W  saturating sum of forward gaps (flits missing)

Behaviour:
- Reset (rst_n=0 sampled at clk): all outputs 0, expected_seq=0, FSM to HUNT. Reset mid-stream discards any flit presented that cycle.
- Latency: exactly 1 cycle, valid_in -> valid_out.
- Data outputs: updated only on an accepted flit and held otherwise. valid_out and seq_err are 0 in cycles without valid_in.
- FSM HUNT:
  - First valid_in: accept without checking and set expected_seq = rx_seq+1 (mod 2^SEQ_W).
  - Assert locked from the next cycle; go to LOCKED.
  - seq_err=0 for this flit.
- FSM LOCKED, each valid_in:
  - delta = rx_seq - expected_seq (mod 2^SEQ_W).
  - delta==0: clean; expected_seq += 1.
  - delta!=0: seq_err=1; err_cnt+=1.
  - Forward gap (delta < 2^(SEQ_W-1)): lost_cnt += delta, clamped to all-ones.
  - Backward or duplicate (delta >= 2^(SEQ_W-1)): lost_cnt is unchanged.
  - After any error, resync: expected_seq = rx_seq+1. Stay in LOCKED.
- Wrap-around: expected all-ones followed by rx_seq 0 is clean. The arithmetic is strictly modular.
- DROP_ON_ERR=1: an errored flit produces valid_out=0, but seq_err still pulses and the counters still update.
- Counters saturate at 2^CNT_W-1 and never wrap. err_cnt/lost_cnt reflect the flit one cycle after it is accepted.
- stats_clr with a simultaneous error: clear wins, and that cycle's increment is discarded. stats_clr does not affect the FSM or expected_seq.
- Only rst_n returns the FSM to HUNT.

Decomposition:
- Package nvlink_pkg holds:
  - PAYLOAD_W/COH_W/SEQ_W defaults;
  - flit field offset localparams (PAYLOAD_LSB=0, SEQ_LSB=PAYLOAD_W, COH_LSB=PAYLOAD_W+SEQ_W);
  - a packed flit struct typedef;
  - the enum typedef {HUNT, LOCKED}.
- One natural sub-module: nvlink_sat_counter (parameterised width, increment amount input, clear, saturate). It is instantiated twice.

Test Plan:
- Reset, then flits seq 0..9 back-to-back:
  - valid_out follows one cycle later with matching fields.
  - locked=1 from the cycle after the first flit.
  - seq_err never asserts; err_cnt=0, lost_cnt=0.
- Start at seq 0xFFFFFE, then 0xFFFFFF, 0x000000, 0x000001: no seq_err (wrap).
- Sequence 5,6,10,11:
  - seq_err only on the flit with seq 10.
  - err_cnt=1, lost_cnt=3; flit 11 is clean.
- Sequence 7,8,8,9:
  - seq_err on the second 8 (duplicate).
  - err_cnt=1, lost_cnt=0; flit 9 is clean.
- DROP_ON_ERR=1 with sequence 1,2,5: no valid_out for seq 5; seq_err=1; lost_cnt=2.
- CNT_W=4 with 20 gaps: err_cnt holds at 15. Then stats_clr together with an error: counters read 0 the next cycle.
- rst_n low mid-stream: outputs 0 next cycle; the next flit (any seq) is accepted in HUNT with no error.
